// File: rtl/hp_ctrl_pkg.sv
// Shared types and constants for the relay-computer instruction sequencer:
// FSM states, opcode classes, register codes and the control-strobe bundle.
package hp_ctrl_pkg;

   typedef enum logic [3:0] {
      RST_IDLE,
      FETCH0,
      FETCH1,
      DECODE,
      EX0,
      EX1,
      G0,
      G1,
      G2,
      G3,
      G4,
      G5,
      HALTED
   } state_t;

   typedef enum logic [3:0] {
      OPC_NOP,
      OPC_MOV8,
      OPC_SETAB,
      OPC_ALU,
      OPC_LOAD,
      OPC_STORE,
      OPC_INCXY,
      OPC_HALT,
      OPC_GOTO
   } op_class_t;

   // ALU function code presented whenever the ALU is not driving the bus
   localparam logic [2:0] ALU_IDLE = 3'b111;

   // r3 register codes; the two-bit rr code is the low half (A..D)
   localparam logic [2:0] R_A  = 3'd0;
   localparam logic [2:0] R_B  = 3'd1;
   localparam logic [2:0] R_C  = 3'd2;
   localparam logic [2:0] R_D  = 3'd3;
   localparam logic [2:0] R_M1 = 3'd4;
   localparam logic [2:0] R_M2 = 3'd5;
   localparam logic [2:0] R_X  = 3'd6;
   localparam logic [2:0] R_Y  = 3'd7;

   // Opcode match values and masks
   localparam logic [1:0] OP_MOV8_HI  = 2'b00;
   localparam logic [1:0] OP_SETAB_HI = 2'b01;
   localparam logic [1:0] OP_GOTO_HI  = 2'b11;
   localparam logic [7:0] MASK_ALU    = 8'hF0;
   localparam logic [7:0] OP_ALU      = 8'h80;
   localparam logic [7:0] MASK_LDST   = 8'hFC;
   localparam logic [7:0] OP_LOAD     = 8'h90;
   localparam logic [7:0] OP_STORE    = 8'h98;
   localparam logic [7:0] OP_INCXY    = 8'hB0;
   localparam logic [7:0] OP_HALT     = 8'hAE;

   // Complete control bundle; ld_reg/sel_reg are indexed by r3 code
   typedef struct packed {
      logic [7:0] ld_reg;
      logic [7:0] sel_reg;
      logic       ld_xy;
      logic       ld_j1;
      logic       ld_j2;
      logic       ld_inst;
      logic       ld_pc;
      logic       ld_inc;
      logic       ld_cond;
      logic       sel_m;
      logic       sel_xy;
      logic       sel_j;
      logic       sel_pc;
      logic       sel_inc;
      logic       sel_imm;
      logic       alu_en;
      logic [2:0] alu_fn;
      logic       mem_read;
      logic       mem_write;
      logic       halt;
      logic       instr_done;
   } ctrl_t;

   function automatic op_class_t decode_op(input logic [7:0] op);
      if (op[7:6] == OP_MOV8_HI)              return OPC_MOV8;
      if (op[7:6] == OP_SETAB_HI)             return OPC_SETAB;
      if (op[7:6] == OP_GOTO_HI)              return OPC_GOTO;
      if ((op & MASK_ALU) == OP_ALU)          return OPC_ALU;
      if ((op & MASK_LDST) == OP_LOAD)        return OPC_LOAD;
      if ((op & MASK_LDST) == OP_STORE)       return OPC_STORE;
      if (op == OP_INCXY)                     return OPC_INCXY;
      if (op == OP_HALT)                      return OPC_HALT;
      return OPC_NOP;
   endfunction

   function automatic logic [7:0] reg_onehot(input logic [2:0] r);
      return 8'd1 << r;
   endfunction

endpackage

// File: rtl/goto_cond.sv
// GOTO branch condition: taken = x | s&sign | c&carry | z&zero | n&~zero,
// with cond_bits = {s, c, z, n, x} taken from inst[4:0].
module goto_cond (
   input  logic [4:0] cond_bits,
   input  logic       zero,
   input  logic       carry,
   input  logic       sign,
   output logic       taken
);

   assign taken = cond_bits[0]
                | (cond_bits[4] & sign)
                | (cond_bits[3] & carry)
                | (cond_bits[2] & zero)
                | (cond_bits[1] & ~zero);

endmodule

// File: rtl/control_sequencer.sv
// Instruction sequencer: fetch, decode and execute micro-steps, one per clock,
// driving every load/select/memory/ALU strobe as a Moore function of the
// current state and the Inst register contents.
module control_sequencer
   import hp_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] inst,
   input  logic       zero,
   input  logic       carry,
   input  logic       sign,
   output logic       LdA,
   output logic       LdB,
   output logic       LdC,
   output logic       LdD,
   output logic       LdX,
   output logic       LdY,
   output logic       LdM1,
   output logic       LdM2,
   output logic       LdXY,
   output logic       LdJ1,
   output logic       LdJ2,
   output logic       LdInst,
   output logic       LdPC,
   output logic       LdINC,
   output logic       LdCond,
   output logic       SelA,
   output logic       SelB,
   output logic       SelC,
   output logic       SelD,
   output logic       SelX,
   output logic       SelY,
   output logic       SelM1,
   output logic       SelM2,
   output logic       SelM,
   output logic       SelXY,
   output logic       SelJ,
   output logic       SelPC,
   output logic       SelINC,
   output logic       sel_imm,
   output logic       alu_en,
   output logic [2:0] AluFunctionCode,
   output logic       MemRead,
   output logic       MemWrite,
   output logic       Halt,
   output logic       instr_done
);

   state_t    state_q;
   state_t    state_d;
   ctrl_t     ctrl;
   op_class_t op;
   logic      taken;

   assign op = decode_op(inst);

   goto_cond u_goto_cond (
      .cond_bits (inst[4:0]),
      .zero      (zero),
      .carry     (carry),
      .sign      (sign),
      .taken     (taken)
   );

   // State register; reset forces RST_IDLE so all strobes drop at once
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= RST_IDLE;
      else        state_q <= state_d;
   end

   // Next-state sequencing and per-state strobe generation
   always_comb begin
      state_d     = state_q;
      ctrl        = '0;
      ctrl.alu_fn = ALU_IDLE;
      case (state_q)
         RST_IDLE: state_d = FETCH0;
         FETCH0: begin
            ctrl.sel_pc   = 1'b1;
            ctrl.mem_read = 1'b1;
            ctrl.ld_inst  = 1'b1;
            ctrl.ld_inc   = 1'b1;
            state_d       = FETCH1;
         end
         FETCH1: begin
            ctrl.sel_inc = 1'b1;
            ctrl.ld_pc   = 1'b1;
            state_d      = DECODE;
         end
         DECODE: begin
            if (op == OPC_HALT)      state_d = HALTED;
            else if (op == OPC_GOTO) state_d = G0;
            else                     state_d = EX0;
         end
         EX0: begin
            case (op)
               OPC_MOV8: begin
                  ctrl.ld_reg = reg_onehot(inst[5:3]);
                  // Self-move leaves the bus floating, which clears the register
                  if (inst[5:3] != inst[2:0]) ctrl.sel_reg = reg_onehot(inst[2:0]);
               end
               OPC_SETAB: begin
                  ctrl.sel_imm = 1'b1;
                  ctrl.ld_reg  = reg_onehot(inst[5] ? R_B : R_A);
               end
               OPC_ALU: begin
                  ctrl.alu_en  = 1'b1;
                  ctrl.alu_fn  = inst[2:0];
                  ctrl.ld_cond = 1'b1;
                  ctrl.ld_reg  = reg_onehot(inst[3] ? R_D : R_A);
               end
               OPC_LOAD: begin
                  ctrl.sel_m    = 1'b1;
                  ctrl.mem_read = 1'b1;
                  ctrl.ld_reg   = reg_onehot({1'b0, inst[1:0]});
               end
               OPC_STORE: begin
                  ctrl.sel_m     = 1'b1;
                  ctrl.sel_reg   = reg_onehot({1'b0, inst[1:0]});
                  ctrl.mem_write = 1'b1;
               end
               OPC_INCXY: begin
                  ctrl.sel_xy = 1'b1;
                  ctrl.ld_inc = 1'b1;
               end
               default: ;
            endcase
            if (op == OPC_INCXY) begin
               state_d = EX1;
            end else begin
               ctrl.instr_done = 1'b1;
               state_d         = FETCH0;
            end
         end
         EX1: begin
            ctrl.sel_inc    = 1'b1;
            ctrl.ld_xy      = 1'b1;
            ctrl.instr_done = 1'b1;
            state_d         = FETCH0;
         end
         G0: begin
            ctrl.sel_pc   = 1'b1;
            ctrl.mem_read = 1'b1;
            ctrl.ld_j1    = 1'b1;
            ctrl.ld_inc   = 1'b1;
            state_d       = G1;
         end
         G1: begin
            ctrl.sel_inc = 1'b1;
            ctrl.ld_pc   = 1'b1;
            state_d      = G2;
         end
         G2: begin
            ctrl.sel_pc   = 1'b1;
            ctrl.mem_read = 1'b1;
            ctrl.ld_j2    = 1'b1;
            ctrl.ld_inc   = 1'b1;
            state_d       = G3;
         end
         G3: begin
            ctrl.sel_inc = 1'b1;
            ctrl.ld_pc   = 1'b1;
            state_d      = G4;
         end
         G4: begin
            // Call form saves the return address (PC) into XY
            if (inst[5]) begin
               ctrl.sel_pc = 1'b1;
               ctrl.ld_xy  = 1'b1;
            end
            state_d = G5;
         end
         G5: begin
            if (taken) begin
               ctrl.sel_j = 1'b1;
               ctrl.ld_pc = 1'b1;
            end
            ctrl.instr_done = 1'b1;
            state_d         = FETCH0;
         end
         HALTED: begin
            ctrl.halt = 1'b1;
            state_d   = HALTED;
         end
         default: state_d = RST_IDLE;
      endcase
   end

   assign LdA             = ctrl.ld_reg[R_A];
   assign LdB             = ctrl.ld_reg[R_B];
   assign LdC             = ctrl.ld_reg[R_C];
   assign LdD             = ctrl.ld_reg[R_D];
   assign LdM1            = ctrl.ld_reg[R_M1];
   assign LdM2            = ctrl.ld_reg[R_M2];
   assign LdX             = ctrl.ld_reg[R_X];
   assign LdY             = ctrl.ld_reg[R_Y];
   assign SelA            = ctrl.sel_reg[R_A];
   assign SelB            = ctrl.sel_reg[R_B];
   assign SelC            = ctrl.sel_reg[R_C];
   assign SelD            = ctrl.sel_reg[R_D];
   assign SelM1           = ctrl.sel_reg[R_M1];
   assign SelM2           = ctrl.sel_reg[R_M2];
   assign SelX            = ctrl.sel_reg[R_X];
   assign SelY            = ctrl.sel_reg[R_Y];
   assign LdXY            = ctrl.ld_xy;
   assign LdJ1            = ctrl.ld_j1;
   assign LdJ2            = ctrl.ld_j2;
   assign LdInst          = ctrl.ld_inst;
   assign LdPC            = ctrl.ld_pc;
   assign LdINC           = ctrl.ld_inc;
   assign LdCond          = ctrl.ld_cond;
   assign SelM            = ctrl.sel_m;
   assign SelXY           = ctrl.sel_xy;
   assign SelJ            = ctrl.sel_j;
   assign SelPC           = ctrl.sel_pc;
   assign SelINC          = ctrl.sel_inc;
   assign sel_imm         = ctrl.sel_imm;
   assign alu_en          = ctrl.alu_en;
   assign AluFunctionCode = ctrl.alu_fn;
   assign MemRead         = ctrl.mem_read;
   assign MemWrite        = ctrl.mem_write;
   assign Halt            = ctrl.halt;
   assign instr_done      = ctrl.instr_done;

endmodule
